lcd_cfah_ctrl: RTL and testbench
================================

# lcd_cfah_ctrl

Bus master for the CFAH character LCD 8-bit parallel interface. Accepts one command or data byte per valid/ready handshake and polls the busy flag until it clears. It then executes the write cycle with programmable tAS/PWEH/tAH/tcycE spacing in clock cycles. Sits directly upstream of the LCD CFAH emulator-checker in the testbench, or of the real panel pins in the design, and drives its rs/rw/en/data inputs.

## Interface
- G_TAS_CYC, 2, cycles rs/rw stable before en rises (min 1)
- G_PWEH_CYC, 12, cycles en held high (min 1)
- G_TAH_CYC, 2, cycles rs/rw/data held after en falls (min 1)
- G_TCYC_CYC, 25, minimum cycles between consecutive en rising edges
- G_POLL_MAX, 255, busy polls before timeout (1..255)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_req_val  in  1  request valid
- i_req_rs  in  1  0 = instruction, 1 = data (DDRAM/CGRAM write)
- i_req_data  in  8  byte to write
- o_req_rdy  out  1  controller idle, request accepted when val & rdy
- o_rs  out  1  LCD register select
- o_rw  out  1  LCD read/write (1 = read)
- o_en  out  1  LCD enable strobe
- io_data  inout  8  LCD data bus, driven only while o_rw = 0
- o_done  out  1  one-cycle pulse, write cycle finished
- o_timeout  out  1  one-cycle pulse, request dropped after G_POLL_MAX busy polls
- o_poll_cnt  out  8  number of polls used by last request

## Operation
- States: IDLE, P_SETUP, P_EN, P_HOLD, W_SETUP, W_EN, W_HOLD.
- IDLE: o_req_rdy = 1. On val & rdy, latch rs/data, clear poll counter, go P_SETUP.
- P_SETUP: o_rs = 0, o_rw = 1, o_en = 0 for G_TAS_CYC cycles → P_EN.
- P_EN: o_en = 1 for G_PWEH_CYC cycles. On the last high cycle, sample io_data[7] as BF and increment the poll counter → P_HOLD.
- P_HOLD: o_en = 0, rs/rw held for L_LOW = max(G_TAH_CYC, G_TCYC_CYC − G_PWEH_CYC) cycles. Then:
  - BF = 0 → W_SETUP.
  - BF = 1 and poll count < G_POLL_MAX → P_SETUP.
  - Otherwise pulse o_timeout, return IDLE, and discard the byte.
- W_SETUP/W_EN/W_HOLD: same durations as the poll cycle, with o_rs = latched rs, o_rw = 0, and io_data = latched byte for the whole cycle. At the end of W_HOLD, pulse o_done and return IDLE.
- io_data = o_rw ? 8'hzz : data register; combinational, so the bus is released in the same cycle rw rises.
- No sampling of io_data during writes; no read-data path.

## Timing
- Reset values: o_rs 0, o_rw 0, o_en 0, data register 0x00 (bus driven 0x00), o_req_rdy 1, o_done 0, o_timeout 0, o_poll_cnt 0, state IDLE.
- Bus-cycle length: L = G_TAS_CYC + G_PWEH_CYC + L_LOW (defaults 2 + 12 + 13 = 27).
- Latency: accept at edge 0; first en rise at edge 1 + G_TAS_CYC. With BF clear on the first poll, o_done is high in cycle 1 + 2L (55 at defaults), and o_req_rdy rises in the same cycle.
- Each extra busy poll adds L cycles.
- en rise-to-rise spacing is ≥ G_TCYC_CYC + G_TAS_CYC. No outputs change while o_en = 1 except o_en itself.
- Requests are ignored while o_req_rdy = 0. Back-to-back: a request presented in the done cycle is accepted on the next edge.
- Reset mid-cycle: o_en drops on the next edge, the bus returns to the reset state, and the pending byte is lost; no o_done is issued.

## Structure
- lcd_cfah_pkg: state enum; BF bit index (7); instruction opcodes:
  - CLEAR 0x01
  - HOME 0x02
  - ENTRY 0x04
  - DISPLAY 0x08
  - SHIFT 0x10
  - FUNCTION 0x20
  - CGRAM 0x40
  - DDRAM 0x80
- One sub-module, lcd_cfah_phase_cnt: a loadable down-counter that emits a terminal-count pulse and times every phase.

## Test plan
- Emulator with busy duration 0: request rs = 0, data 0x38 → one poll, en high 12 cycles, emulator logs FUNCTION_SET, o_done at cycle 55, o_poll_cnt = 1.
- Emulator busy duration 3: request rs = 1, data 0x41 → 4 polls, then WR_DATA with 0x41, o_done at cycle 1 + 5 × 27 = 136.
- Emulator forced BF = 1 (i_wdata_sel = 1, i_wdata = 0x80), G_POLL_MAX = 4 → o_timeout after 4 polls at cycle 109, no write cycle, o_done stays 0.
- Sequence 0x80 then "HI" as data → emulator DDRAM line 0 holds 0x48 0x49. No checker tAS/PWEH/tcycE/tAH errors reported.
- Assert rst_n low while o_en = 1 → o_en = 0 next cycle, o_req_rdy = 1, no o_done. A new request afterwards completes normally.
- Hold i_req_val high with changing data during a transfer → only the byte sampled at the accept edge is written.

Source files
------------

// File: rtl/lcd_cfah_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_cfah_pkg                                                          |
// | Shared types and constants for the CFAH character LCD bus master.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package lcd_cfah_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_SETUP = 3'd1,
        P_EN    = 3'd2,
        P_HOLD  = 3'd3,
        W_SETUP = 3'd4,
        W_EN    = 3'd5,
        W_HOLD  = 3'd6
    } state_t;

    localparam int c_bf_bit = 7;

    localparam logic [7:0] c_op_clear    = 8'h01;
    localparam logic [7:0] c_op_home     = 8'h02;
    localparam logic [7:0] c_op_entry    = 8'h04;
    localparam logic [7:0] c_op_display  = 8'h08;
    localparam logic [7:0] c_op_shift    = 8'h10;
    localparam logic [7:0] c_op_function = 8'h20;
    localparam logic [7:0] c_op_cgram    = 8'h40;
    localparam logic [7:0] c_op_ddram    = 8'h80;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cfah_phase_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_cfah_phase_cnt                                                    |
// | Loadable down-counter; o_tc is high while the count sits at zero.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module lcd_cfah_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_cfah_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_cfah_ctrl                                                         |
// | CFAH 8-bit LCD bus master: busy-flag polling then one timed write.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module lcd_cfah_ctrl
    import lcd_cfah_pkg::*;
#(
    parameter int G_TAS_CYC  = 2,
    parameter int G_PWEH_CYC = 12,
    parameter int G_TAH_CYC  = 2,
    parameter int G_TCYC_CYC = 25,
    parameter int G_POLL_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req_val,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_req_rdy,
    output logic       o_rs,
    output logic       o_rw,
    output logic       o_en,
    inout  wire  [7:0] io_data,
    output logic       o_done,
    output logic       o_timeout,
    output logic [7:0] o_poll_cnt
);

    localparam int CNT_W = 16;
    localparam int L_LOW = max_int(G_TAH_CYC, G_TCYC_CYC - G_PWEH_CYC);

    localparam logic [CNT_W-1:0] c_tas_ld  = CNT_W'(G_TAS_CYC - 1);
    localparam logic [CNT_W-1:0] c_pweh_ld = CNT_W'(G_PWEH_CYC - 1);
    localparam logic [CNT_W-1:0] c_low_ld  = CNT_W'(L_LOW - 1);
    localparam logic [7:0]       c_poll_max = 8'(G_POLL_MAX);

    state_t           r_state;
    state_t           w_next;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             r_bf;
    logic [7:0]       r_poll_cnt;
    logic             r_done;
    logic             r_timeout;

    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_tc;
    logic             w_accept;
    logic             w_poll_end;
    logic             w_done;
    logic             w_timeout;
    logic             w_unused_bus;

    lcd_cfah_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_accept   = 1'b0;
        w_poll_end = 1'b0;
        w_done     = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_val) begin
                    w_accept   = 1'b1;
                    w_next     = P_SETUP;
                    w_load     = 1'b1;
                    w_load_val = c_tas_ld;
                end
            end
            P_SETUP: begin
                if (w_tc) begin
                    w_next     = P_EN;
                    w_load     = 1'b1;
                    w_load_val = c_pweh_ld;
                end
            end
            P_EN: begin
                if (w_tc) begin
                    w_poll_end = 1'b1;
                    w_next     = P_HOLD;
                    w_load     = 1'b1;
                    w_load_val = c_low_ld;
                end
            end
            P_HOLD: begin
                if (w_tc) begin
                    // r_poll_cnt already includes the poll that just ended
                    if (!r_bf) begin
                        w_next     = W_SETUP;
                        w_load     = 1'b1;
                        w_load_val = c_tas_ld;
                    end else if (r_poll_cnt < c_poll_max) begin
                        w_next     = P_SETUP;
                        w_load     = 1'b1;
                        w_load_val = c_tas_ld;
                    end else begin
                        w_next    = IDLE;
                        w_timeout = 1'b1;
                    end
                end
            end
            W_SETUP: begin
                if (w_tc) begin
                    w_next     = W_EN;
                    w_load     = 1'b1;
                    w_load_val = c_pweh_ld;
                end
            end
            W_EN: begin
                if (w_tc) begin
                    w_next     = W_HOLD;
                    w_load     = 1'b1;
                    w_load_val = c_low_ld;
                end
            end
            W_HOLD: begin
                if (w_tc) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs       <= 1'b0;
            r_data     <= 8'h00;
            r_bf       <= 1'b0;
            r_poll_cnt <= 8'h00;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done    <= w_done;
            r_timeout <= w_timeout;
            if (w_accept) begin
                r_rs       <= i_req_rs;
                r_data     <= i_req_data;
                r_poll_cnt <= 8'h00;
            end
            if (w_poll_end) begin
                r_bf       <= io_data[c_bf_bit];
                r_poll_cnt <= r_poll_cnt + 8'h01;
            end
        end
    end

    // Outputs decode straight from state so nothing but en moves while en is high
    assign o_req_rdy  = (r_state == IDLE);
    assign o_en       = (r_state == P_EN) || (r_state == W_EN);
    assign o_rw       = (r_state == P_SETUP) || (r_state == P_EN) || (r_state == P_HOLD);
    assign o_rs       = ((r_state == W_SETUP) || (r_state == W_EN) || (r_state == W_HOLD)) ? r_rs : 1'b0;
    assign o_done     = r_done;
    assign o_timeout  = r_timeout;
    assign o_poll_cnt = r_poll_cnt;

    assign io_data      = o_rw ? 8'hzz : r_data;
    assign w_unused_bus = &{1'b0, io_data[6:0]};

endmodule
`default_nettype wire

// File: tb/tb_lcd_cfah_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_cfah_ctrl                                                      |
// | Scoreboard bench with a small behavioural CFAH panel model.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_lcd_cfah_ctrl;

    localparam int L        = 27;
    localparam int PWEH     = 12;
    localparam int MIN_RISE = 27;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_req_val = 1'b0;
    logic       i_req_rs = 1'b0;
    logic [7:0] i_req_data = 8'h00;
    logic       o_req_rdy, o_rs, o_rw, o_en, o_done, o_timeout;
    logic [7:0] o_poll_cnt;
    wire  [7:0] io_data;

    lcd_cfah_ctrl #(
        .G_TAS_CYC  (2),
        .G_PWEH_CYC (12),
        .G_TAH_CYC  (2),
        .G_TCYC_CYC (25),
        .G_POLL_MAX (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_val  (i_req_val),
        .i_req_rs   (i_req_rs),
        .i_req_data (i_req_data),
        .o_req_rdy  (o_req_rdy),
        .o_rs       (o_rs),
        .o_rw       (o_rw),
        .o_en       (o_en),
        .io_data    (io_data),
        .o_done     (o_done),
        .o_timeout  (o_timeout),
        .o_poll_cnt (o_poll_cnt)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Panel model: answers busy reads, logs writes, keeps a DDRAM image
    int         busy_cfg = 0;
    bit         force_bf = 1'b0;
    int         reads_done = 0;
    logic       lcd_bf;
    logic [7:0] ddram [0:127];
    logic [6:0] ddr_addr = 7'd0;

    assign lcd_bf  = force_bf || (reads_done < busy_cfg);
    assign io_data = (o_rw && o_en) ? {lcd_bf, 7'h00} : 8'hzz;

    typedef struct {
        bit         rs;
        logic [7:0] d;
    } wr_t;
    wr_t wr_q[$];

    logic       en_prev = 1'b0;
    int         rise_edge = 0;
    int         prev_rise = -1000;
    logic       rs_r, rw_r;
    logic [7:0] d_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev    = 1'b0;
            prev_rise  = -1000;
            reads_done = 0;
        end else begin
            if (o_req_rdy) reads_done = 0;
            if (o_en && !en_prev) begin
                if (prev_rise > -1000) chk("en_rise_spacing_ok", int'(edge_cnt - prev_rise >= MIN_RISE), 1);
                prev_rise = edge_cnt;
                rise_edge = edge_cnt;
                rs_r = o_rs;
                rw_r = o_rw;
                d_r  = io_data;
            end else if (o_en) begin
                chk("rs_stable_en_high", o_rs, rs_r);
                chk("rw_stable_en_high", o_rw, rw_r);
                if (!rw_r) chk("data_stable_en_high", io_data, d_r);
            end else if (en_prev) begin
                chk("en_high_width", edge_cnt - rise_edge, PWEH);
                if (rw_r) begin
                    reads_done++;
                end else begin
                    wr_q.push_back('{rs: rs_r, d: d_r});
                    if (rs_r) begin
                        ddram[ddr_addr] = d_r;
                        ddr_addr        = ddr_addr + 7'd1;
                    end else if (d_r[7]) begin
                        ddr_addr = d_r[6:0];
                    end
                end
            end
            en_prev = o_en;
        end
    end

    // Scoreboard
    typedef struct {
        bit         is_to;
        int         polls;
        int         cyc;
        bit         rs;
        logic [7:0] d;
        int         acc;
    } exp_t;
    exp_t exp_q[$];
    int   done_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (rst_n && (o_done || o_timeout)) begin
            if (o_done) done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("completion_is_timeout", o_timeout, e.is_to);
                chk("completion_is_done", o_done, !e.is_to);
                chk("poll_cnt", o_poll_cnt, e.polls);
                chk("completion_cycle", edge_cnt - e.acc + 1, e.cyc);
                if (e.is_to) begin
                    chk("no_write_on_timeout", wr_q.size(), 0);
                end else if (wr_q.size() == 0) begin
                    chk("write_logged", 0, 1);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_rs", w.rs, e.rs);
                    chk("write_data", w.d, e.d);
                end
            end
        end
    end

    task automatic wait_rdy();
        int n = 0;
        @(negedge clk);
        while (!o_req_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("wait_rdy_timeout", 0, 1);
    endtask

    // Presents a request at a negedge; it is accepted on the following posedge
    task automatic send(input bit rs, input logic [7:0] d, input int busy, input bit frc,
                        input bit is_to, input int polls, input int cyc, input bit track);
        wait_rdy();
        busy_cfg   = busy;
        force_bf   = frc;
        i_req_rs   = rs;
        i_req_data = d;
        i_req_val  = 1'b1;
        if (track) exp_q.push_back('{is_to: is_to, polls: polls, cyc: cyc, rs: rs, d: d, acc: edge_cnt + 1});
        @(posedge clk);
        #1 i_req_val = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        int done_before;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rs", o_rs, 0);
        chk("reset_rw", o_rw, 0);
        chk("reset_en", o_en, 0);
        chk("reset_bus", io_data, 8'h00);
        chk("reset_rdy", o_req_rdy, 1);
        chk("reset_done", o_done, 0);
        chk("reset_timeout", o_timeout, 0);
        chk("reset_poll_cnt", o_poll_cnt, 0);
        rst_n = 1'b1;

        // Function set, panel never busy
        send(1'b0, 8'h38, 0, 1'b0, 1'b0, 1, 55, 1'b1);
        drain();

        // Data 'A' after three busy polls
        send(1'b1, 8'h41, 3, 1'b0, 1'b0, 4, 136, 1'b1);
        drain();

        // Stuck busy flag: four polls then timeout, no write
        send(1'b0, 8'h01, 0, 1'b1, 1'b1, 4, 109, 1'b1);
        drain();
        force_bf = 1'b0;

        // Set DDRAM address 0 then write "HI" back to back
        send(1'b0, 8'h80, 0, 1'b0, 1'b0, 1, 55, 1'b1);
        send(1'b1, 8'h48, 0, 1'b0, 1'b0, 1, 55, 1'b1);
        send(1'b1, 8'h49, 0, 1'b0, 1'b0, 1, 55, 1'b1);
        drain();
        chk("ddram_0", ddram[0], 8'h48);
        chk("ddram_1", ddram[1], 8'h49);

        // Valid held high with changing data during the transfer
        wait_rdy();
        busy_cfg   = 0;
        i_req_rs   = 1'b1;
        i_req_data = 8'h4A;
        i_req_val  = 1'b1;
        exp_q.push_back('{is_to: 1'b0, polls: 1, cyc: 55, rs: 1'b1, d: 8'h4A, acc: edge_cnt + 1});
        @(posedge clk);
        repeat (40) begin
            @(negedge clk);
            i_req_data = i_req_data + 8'h01;
        end
        i_req_val = 1'b0;
        drain();
        chk("ddram_2_held_val", ddram[2], 8'h4A);

        // Reset while en is high
        send(1'b0, 8'h0C, 0, 1'b0, 1'b0, 1, 55, 1'b0);
        n = 0;
        while (!o_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("en_seen_before_reset", o_en, 1);
        done_before = done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_mid_en", o_en, 0);
        chk("reset_mid_rdy", o_req_rdy, 1);
        chk("reset_mid_rw", o_rw, 0);
        chk("reset_mid_bus", io_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("no_done_after_reset", done_cnt, done_before);
        wr_q.delete();

        send(1'b0, 8'h06, 0, 1'b0, 1'b0, 1, 55, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
